// File: rtl/ldpc_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_pkg
// Shared definitions for the LDPC node compute core:
//   - message format (two's complement Q8.8)
//   - node degrees
//   - check-node offset used when CN_OFFSET_MIN_SUM_EN is defined
//   - helpers for symmetric saturation and clamped magnitude
// ---------------------------------------------------------------------------
package ldpc_pkg;

  localparam int MSG_W = 16;
  localparam int DEG_C = 6;
  localparam int DEG_V = 3;

  typedef logic signed [MSG_W-1:0] msg_t;
  typedef logic        [MSG_W-1:0] mag_t;
  // Three guard bits hold the sum of four messages without overflow.
  typedef logic signed [MSG_W+2:0] wide_t;

  localparam mag_t CN_OFFSET = 16'h0020;

  localparam msg_t MSG_MAX = 16'sh7FFF;
  localparam msg_t MSG_MIN = 16'sh8000;
  localparam msg_t MSG_NEG = 16'sh8001;

  // Symmetric clamp to [-32767, +32767]; 0x8000 is never produced.
  function automatic msg_t sat_msg(input wide_t x);
    if (x > wide_t'(MSG_MAX)) begin
      return MSG_MAX;
    end else if (x < wide_t'(MSG_NEG)) begin
      return MSG_NEG;
    end else begin
      return msg_t'(x[MSG_W-1:0]);
    end
  endfunction

  // Magnitude with -32768 folded onto 32767 so it fits a positive message.
  function automatic mag_t abs_msg(input msg_t x);
    if (x == MSG_MIN) begin
      return mag_t'(MSG_MAX);
    end else if (x < 0) begin
      return mag_t'(-x);
    end else begin
      return mag_t'(x);
    end
  endfunction

endpackage

// File: rtl/ldpc_node_core_if.sv
// ---------------------------------------------------------------------------
// ldpc_node_core_if
// Bus between the decoder FSM (master) and the node compute core (slave).
//   in_valid, cn_msg_in, llr_in, vn_chk_msg_in, syn_bits_in : master -> core
//   out_valid, cn_msg_out, vn_msg_out, belief_out,
//   hard_bit_out, syn_out                                   : core -> master
// Message slot i occupies bits [MSG_W*i +: MSG_W] of the packed vectors.
// ---------------------------------------------------------------------------
interface ldpc_node_core_if;
  import ldpc_pkg::*;

  logic                   in_valid;
  logic [DEG_C*MSG_W-1:0] cn_msg_in;
  logic [MSG_W-1:0]       llr_in;
  logic [DEG_V*MSG_W-1:0] vn_chk_msg_in;
  logic [DEG_C-1:0]       syn_bits_in;

  logic                   out_valid;
  logic [DEG_C*MSG_W-1:0] cn_msg_out;
  logic [DEG_V*MSG_W-1:0] vn_msg_out;
  logic [MSG_W-1:0]       belief_out;
  logic                   hard_bit_out;
  logic                   syn_out;

  modport master (
    output in_valid, cn_msg_in, llr_in, vn_chk_msg_in, syn_bits_in,
    input  out_valid, cn_msg_out, vn_msg_out, belief_out, hard_bit_out, syn_out
  );

  modport slave (
    input  in_valid, cn_msg_in, llr_in, vn_chk_msg_in, syn_bits_in,
    output out_valid, cn_msg_out, vn_msg_out, belief_out, hard_bit_out, syn_out
  );

endinterface

// File: rtl/ldpc_cn_minsum.sv
// ---------------------------------------------------------------------------
// ldpc_cn_minsum
// Combinational degree-6 min-sum check node.
//   msg_in  : var->check messages, slot i at [MSG_W*i +: MSG_W]
//   msg_out : check->var extrinsic messages, same slot layout
// Each output carries the minimum magnitude and the XOR of the signs of
// all other inputs, found with a single two-minimum search.
// Optional: CN_OFFSET_MIN_SUM_EN subtracts CN_OFFSET from every output
// magnitude, flooring at zero.
// ---------------------------------------------------------------------------
module ldpc_cn_minsum
  import ldpc_pkg::*;
(
  input  logic [DEG_C*MSG_W-1:0] msg_in,
  output logic [DEG_C*MSG_W-1:0] msg_out
);

  mag_t       mag [DEG_C];
  logic       sgn [DEG_C];
  mag_t       min1;
  mag_t       min2;
  logic [2:0] idx1;
  logic       sign_all;
  mag_t       mag_o;
  logic       sign_o;

  // NOTE: blocking assignments here model combinational data flow; every
  // variable gets a default first so no latch is inferred.
  always_comb begin
    min1     = '1;
    min2     = '1;
    idx1     = '0;
    sign_all = 1'b0;
    mag_o    = '0;
    sign_o   = 1'b0;
    msg_out  = '0;

    for (int j = 0; j < DEG_C; j++) begin
      mag[j]   = abs_msg(msg_t'(msg_in[MSG_W*j +: MSG_W]));
      sgn[j]   = msg_in[MSG_W*j + MSG_W-1];
      sign_all = sign_all ^ sgn[j];
      // Strict compare keeps the lowest index on ties.
      if (mag[j] < min1) begin
        min2 = min1;
        min1 = mag[j];
        idx1 = 3'(j);
      end else if (mag[j] < min2) begin
        min2 = mag[j];
      end
    end

    for (int i = 0; i < DEG_C; i++) begin
      mag_o  = (3'(i) == idx1) ? min2 : min1;
`ifdef CN_OFFSET_MIN_SUM_EN
      mag_o  = (mag_o > CN_OFFSET) ? (mag_o - CN_OFFSET) : '0;
`endif
      sign_o = sign_all ^ sgn[i];
      // A zero magnitude stays 0x0000 whatever the sign.
      if (mag_o == '0) begin
        msg_out[MSG_W*i +: MSG_W] = '0;
      end else if (sign_o) begin
        msg_out[MSG_W*i +: MSG_W] = -mag_o;
      end else begin
        msg_out[MSG_W*i +: MSG_W] = mag_o;
      end
    end
  end

endmodule

// File: rtl/ldpc_node_core.sv
// ---------------------------------------------------------------------------
// ldpc_node_core
// One-stage compute core of the serial LDPC belief-propagation decoder.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every output
//   bus : ldpc_node_core_if.slave (inputs and registered results)
// Per cycle it evaluates a degree-6 min-sum check node (ldpc_cn_minsum),
// a degree-3 variable node (extrinsic messages + saturated belief) and a
// 6-input syndrome parity. Latency is one cycle; data registers load every
// cycle and out_valid tracks in_valid.
// Build option: CN_OFFSET_MIN_SUM_EN selects offset min-sum in the check node.
// ---------------------------------------------------------------------------
module ldpc_node_core
  import ldpc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ldpc_node_core_if.slave  bus
);

  logic                   valid_d,    valid_q;
  logic [DEG_C*MSG_W-1:0] cn_msg_d,   cn_msg_q;
  logic [DEG_V*MSG_W-1:0] vn_msg_d,   vn_msg_q;
  msg_t                   belief_d,   belief_q;
  logic                   hard_bit_d, hard_bit_q;
  logic                   syn_d,      syn_q;

  logic [DEG_C*MSG_W-1:0] cn_result;
  wide_t                  sum;
  msg_t                   ch [DEG_V];

  ldpc_cn_minsum u_cn (
    .msg_in  (bus.cn_msg_in),
    .msg_out (cn_result)
  );

  // Variable node: full-precision sum, saturate only the final values.
  always_comb begin
    valid_d  = bus.in_valid;
    syn_d    = ^bus.syn_bits_in;
    cn_msg_d = cn_result;
    vn_msg_d = '0;
    sum      = wide_t'(msg_t'(bus.llr_in));
    for (int k = 0; k < DEG_V; k++) begin
      ch[k] = msg_t'(bus.vn_chk_msg_in[MSG_W*k +: MSG_W]);
      sum   = sum + wide_t'(ch[k]);
    end
    belief_d = sat_msg(sum);
    for (int k = 0; k < DEG_V; k++) begin
      vn_msg_d[MSG_W*k +: MSG_W] = sat_msg(sum - wide_t'(ch[k]));
    end
    // Registered separately so reset drives the decision to 0, not ~0.
    hard_bit_d = ~belief_d[MSG_W-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      cn_msg_q   <= '0;
      vn_msg_q   <= '0;
      belief_q   <= '0;
      hard_bit_q <= 1'b0;
      syn_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      cn_msg_q   <= cn_msg_d;
      vn_msg_q   <= vn_msg_d;
      belief_q   <= belief_d;
      hard_bit_q <= hard_bit_d;
      syn_q      <= syn_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.cn_msg_out   = cn_msg_q;
  assign bus.vn_msg_out   = vn_msg_q;
  assign bus.belief_out   = belief_q;
  assign bus.hard_bit_out = hard_bit_q;
  assign bus.syn_out      = syn_q;

endmodule

// File: tb/tb_ldpc_node_core.sv
// ---------------------------------------------------------------------------
// tb_ldpc_node_core
// Directed vectors with hand-computed expectations for ldpc_node_core.
// Expected check-node outputs follow CN_OFFSET_MIN_SUM_EN when defined.
// ---------------------------------------------------------------------------
module tb_ldpc_node_core;
  import ldpc_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  ldpc_node_core_if bus ();

  ldpc_node_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DEG_C*MSG_W-1:0] pack6(
    input logic [15:0] a0, a1, a2, a3, a4, a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [DEG_V*MSG_W-1:0] pack3(
    input logic [15:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  task automatic drive(input logic v, input logic [DEG_C*MSG_W-1:0] cn,
                       input logic [15:0] llr, input logic [DEG_V*MSG_W-1:0] ch,
                       input logic [DEG_C-1:0] syn);
    bus.in_valid      = v;
    bus.cn_msg_in     = cn;
    bus.llr_in        = llr;
    bus.vn_chk_msg_in = ch;
    bus.syn_bits_in   = syn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus vectors
  logic [DEG_C*MSG_W-1:0] cn_a, cn_zero, cn_big, cn_small;
  logic [DEG_C*MSG_W-1:0] exp_cn_a, exp_cn_big, exp_cn_small;

  task automatic check_outputs_zero(input string tag);
    check({tag, " out_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, " cn_msg"},    128'(bus.cn_msg_out), 128'(0));
    check({tag, " vn_msg"},    128'(bus.vn_msg_out), 128'(0));
    check({tag, " belief"},    128'(bus.belief_out), 128'(0));
    check({tag, " hard_bit"},  128'(bus.hard_bit_out), 128'(0));
    check({tag, " syn"},       128'(bus.syn_out), 128'(0));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;

    cn_a     = pack6(16'h0100, 16'hFE00, 16'h0300, 16'h0080, 16'h0400, 16'h0500);
    cn_zero  = '0;
    cn_big   = pack6(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    cn_small = pack6(16'h0010, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
`ifdef CN_OFFSET_MIN_SUM_EN
    exp_cn_a     = pack6(16'hFFA0, 16'h0060, 16'hFFA0, 16'hFF20, 16'hFFA0, 16'hFFA0);
    exp_cn_big   = pack6(16'h7FDF, 16'h8021, 16'h8021, 16'h8021, 16'h8021, 16'h8021);
    exp_cn_small = pack6(16'h00E0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
`else
    exp_cn_a     = pack6(16'hFF80, 16'h0080, 16'hFF80, 16'hFF00, 16'hFF80, 16'hFF80);
    exp_cn_big   = pack6(16'h7FFF, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001);
    exp_cn_small = pack6(16'h0100, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
`endif

    // Reset state
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    #1;
    check_outputs_zero("reset");
    step();
    check_outputs_zero("reset held");
    @(negedge clk);
    rst = 1'b0;

    // Three back-to-back valid inputs
    drive(1'b1, cn_a, 16'h0200, pack3(16'h0100, 16'hFF00, 16'h0300), 6'b101100);
    step();
    check("t1 out_valid", 128'(bus.out_valid), 128'(1));
    check("t1 syn",       128'(bus.syn_out), 128'(1));
    check("t1 cn_msg",    128'(bus.cn_msg_out), 128'(exp_cn_a));
    check("t1 belief",    128'(bus.belief_out), 128'(16'h0500));
    check("t1 vn_msg",    128'(bus.vn_msg_out),
          128'(pack3(16'h0400, 16'h0600, 16'h0200)));
    check("t1 hard_bit",  128'(bus.hard_bit_out), 128'(1));

    drive(1'b1, cn_zero, 16'hFE00, pack3(16'hFF00, 16'h0100, 16'hFD00), 6'b000000);
    step();
    check("t2 out_valid", 128'(bus.out_valid), 128'(1));
    check("t2 syn",       128'(bus.syn_out), 128'(0));
    check("t2 cn_msg",    128'(bus.cn_msg_out), 128'(0));
    check("t2 belief",    128'(bus.belief_out), 128'(16'hFB00));
    check("t2 vn_msg",    128'(bus.vn_msg_out),
          128'(pack3(16'hFC00, 16'hFA00, 16'hFE00)));
    check("t2 hard_bit",  128'(bus.hard_bit_out), 128'(0));

    drive(1'b1, cn_big, 16'h7000, pack3(16'h7000, 16'h7000, 16'h7000), 6'b111111);
    step();
    check("t3 out_valid", 128'(bus.out_valid), 128'(1));
    check("t3 syn",       128'(bus.syn_out), 128'(0));
    check("t3 cn_msg",    128'(bus.cn_msg_out), 128'(exp_cn_big));
    check("t3 belief",    128'(bus.belief_out), 128'(16'h7FFF));
    check("t3 vn_msg",    128'(bus.vn_msg_out),
          128'(pack3(16'h7FFF, 16'h7FFF, 16'h7FFF)));
    check("t3 hard_bit",  128'(bus.hard_bit_out), 128'(1));

    // in_valid low: data still loads, out_valid drops
    drive(1'b0, cn_small, 16'h8000, pack3(16'h8000, 16'h8000, 16'h8000), 6'b000001);
    step();
    check("t4 out_valid", 128'(bus.out_valid), 128'(0));
    check("t4 syn",       128'(bus.syn_out), 128'(1));
    check("t4 cn_msg",    128'(bus.cn_msg_out), 128'(exp_cn_small));
    check("t4 belief",    128'(bus.belief_out), 128'(16'h8001));
    check("t4 vn_msg",    128'(bus.vn_msg_out),
          128'(pack3(16'h8001, 16'h8001, 16'h8001)));
    check("t4 hard_bit",  128'(bus.hard_bit_out), 128'(0));

    // Asynchronous reset mid-stream
    drive(1'b1, cn_a, 16'h0200, pack3(16'h0100, 16'hFF00, 16'h0300), 6'b101100);
    step();
    check("pre-rst out_valid", 128'(bus.out_valid), 128'(1));
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async rst");
    step();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, cn_a, 16'h0200, pack3(16'h0100, 16'hFF00, 16'h0300), 6'b101100);
    step();
    check("post-rst idle valid", 128'(bus.out_valid), 128'(0));

    // First valid after reset release
    drive(1'b1, cn_zero, 16'hFE00, pack3(16'hFF00, 16'h0100, 16'hFD00), 6'b000111);
    step();
    check("post-rst out_valid", 128'(bus.out_valid), 128'(1));
    check("post-rst belief",    128'(bus.belief_out), 128'(16'hFB00));
    check("post-rst syn",       128'(bus.syn_out), 128'(1));
    drive(1'b0, cn_zero, '0, '0, '0);
    step();
    check("final out_valid",    128'(bus.out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
